// File: rtl/rv_branch_predictor.sv
// IF-stage branch predictor: 16-entry direct-mapped BTB with 2-bit saturating counters, updated from ID.
// Optional macro RVX_BP_BYPASS_EN forwards a same-index update into the lookup within the same cycle.
module rv_branch_predictor #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic            upd_mispredict
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = XLEN - IDX_W - 2;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic             r_valid  [DEPTH];
    logic [TAG_W-1:0] r_tag    [DEPTH];
    logic [XLEN-1:0]  r_target [DEPTH];
    logic [1:0]       r_ctr    [DEPTH];
    logic             r_mispredict;

    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_upd_write;
    logic             w_nxt_valid;
    logic [TAG_W-1:0] w_nxt_tag;
    logic [XLEN-1:0]  w_nxt_target;
    logic [1:0]       w_nxt_ctr;
    logic             w_mispredict;
    logic [1:0]       w_unused_lsbs;

    assign w_upd_idx     = upd_pc[IDX_W+1:2];
    assign w_upd_tag     = upd_pc[XLEN-1:IDX_W+2];
    assign w_upd_hit     = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_unused_lsbs = fetch_pc[1:0] ^ upd_pc[1:0];

    // Next-state of the indexed entry; a not-taken miss leaves the table alone.
    always_comb begin
        w_upd_write  = 1'b0;
        w_nxt_valid  = r_valid[w_upd_idx];
        w_nxt_tag    = r_tag[w_upd_idx];
        w_nxt_target = r_target[w_upd_idx];
        w_nxt_ctr    = r_ctr[w_upd_idx];
        if (upd_valid && !rst) begin
            if (w_upd_hit) begin
                w_upd_write = 1'b1;
                if (upd_taken) begin
                    w_nxt_ctr    = sat_inc(r_ctr[w_upd_idx]);
                    w_nxt_target = upd_target;
                end else begin
                    w_nxt_ctr = sat_dec(r_ctr[w_upd_idx]);
                end
            end else if (upd_taken) begin
                w_upd_write  = 1'b1;
                w_nxt_valid  = 1'b1;
                w_nxt_tag    = w_upd_tag;
                w_nxt_target = upd_target;
                w_nxt_ctr    = 2'b10;
            end
        end
    end

    assign w_mispredict = upd_valid &&
        ((upd_taken != (w_upd_hit && r_ctr[w_upd_idx][1])) ||
         (w_upd_hit && upd_taken && (upd_target != r_target[w_upd_idx])));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
            r_mispredict <= 1'b0;
        end else begin
            if (w_upd_write) begin
                r_valid[w_upd_idx]  <= w_nxt_valid;
                r_tag[w_upd_idx]    <= w_nxt_tag;
                r_target[w_upd_idx] <= w_nxt_target;
                r_ctr[w_upd_idx]    <= w_nxt_ctr;
            end
            r_mispredict <= w_mispredict;
        end
    end

    assign upd_mispredict = r_mispredict;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    logic [XLEN-1:0]  w_rd_target;
    logic [1:0]       w_rd_ctr;
    logic             w_hit;

    assign w_f_idx = fetch_pc[IDX_W+1:2];
    assign w_f_tag = fetch_pc[XLEN-1:IDX_W+2];

`ifdef RVX_BP_BYPASS_EN
    logic w_byp;
    assign w_byp       = w_upd_write && (w_upd_idx == w_f_idx);
    assign w_rd_valid  = w_byp ? w_nxt_valid  : r_valid[w_f_idx];
    assign w_rd_tag    = w_byp ? w_nxt_tag    : r_tag[w_f_idx];
    assign w_rd_target = w_byp ? w_nxt_target : r_target[w_f_idx];
    assign w_rd_ctr    = w_byp ? w_nxt_ctr    : r_ctr[w_f_idx];
`else
    assign w_rd_valid  = r_valid[w_f_idx];
    assign w_rd_tag    = r_tag[w_f_idx];
    assign w_rd_target = r_target[w_f_idx];
    assign w_rd_ctr    = r_ctr[w_f_idx];
`endif

    // Reset masks the lookup so the first reset cycle never reports stale entries.
    assign w_hit       = !rst && w_rd_valid && (w_rd_tag == w_f_tag);
    assign pred_hit    = w_hit;
    assign pred_taken  = w_hit && w_rd_ctr[1];
    assign pred_target = w_hit ? w_rd_target : fetch_pc + XLEN'(4);

endmodule

// File: tb/tb_rv_branch_predictor.sv
// Directed self-checking bench for rv_branch_predictor.
module tb_rv_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    int n_tests = 0;
    int n_fail  = 0;

    rv_branch_predictor #(.XLEN(32), .IDX_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One update cycle; returns #1 after the capturing edge with upd_valid dropped.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        @(posedge clk); #1;
        upd_valid  = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        fetch_pc = pc;
        #1;
    endtask

    initial begin
        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        fetch_pc = 32'h100;
        @(posedge clk); #1;
        rst = 1'b0;
        look(32'h100);
        chk("rst_hit",    {31'd0, pred_hit},   32'd0);
        chk("rst_taken",  {31'd0, pred_taken}, 32'd0);
        chk("rst_target", pred_target,         32'h104);
        chk("rst_mis",    {31'd0, upd_mispredict}, 32'd0);

        // Allocate 0x100 -> 0x80, ctr=10
        upd(32'h100, 1'b1, 32'h80);
        chk("alloc_mis", {31'd0, upd_mispredict}, 32'd1);
        look(32'h100);
        chk("alloc_hit",    {31'd0, pred_hit},   32'd1);
        chk("alloc_taken",  {31'd0, pred_taken}, 32'd1);
        chk("alloc_target", pred_target,         32'h80);
        @(posedge clk); #1;
        chk("mis_idle", {31'd0, upd_mispredict}, 32'd0);

        // Saturation: ctr 10 -> 11 x4, then 10, then 01
        for (int i = 0; i < 4; i++) upd(32'h100, 1'b1, 32'h80);
        chk("sat_mis", {31'd0, upd_mispredict}, 32'd0);
        upd(32'h100, 1'b0, 32'h0);
        chk("nt1_mis", {31'd0, upd_mispredict}, 32'd1);
        look(32'h100);
        chk("nt1_taken", {31'd0, pred_taken}, 32'd1);
        upd(32'h100, 1'b0, 32'h0);
        chk("nt2_mis", {31'd0, upd_mispredict}, 32'd1);
        look(32'h100);
        chk("nt2_taken", {31'd0, pred_taken}, 32'd0);
        chk("nt2_hit",   {31'd0, pred_hit},   32'd1);

        // Same-cycle hazard: ctr=01 at 0x100, taken update while fetching 0x100
        fetch_pc = 32'h100; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80;
        #1;
`ifdef RVX_BP_BYPASS_EN
        chk("haz_same", {31'd0, pred_taken}, 32'd1);
`else
        chk("haz_same", {31'd0, pred_taken}, 32'd0);
`endif
        @(posedge clk); #1;
        upd_valid = 1'b0;
        #1;
        chk("haz_next", {31'd0, pred_taken}, 32'd1);
        chk("haz_mis",  {31'd0, upd_mispredict}, 32'd1);

        // Reset takes precedence over a simultaneous update
        rst = 1'b1; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80;
        #1;
        chk("rstp_during", {31'd0, pred_hit}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; upd_valid = 1'b0;
        look(32'h100);
        chk("rstp_hit",    {31'd0, pred_hit}, 32'd0);
        chk("rstp_target", pred_target,       32'h104);
        chk("rstp_mis",    {31'd0, upd_mispredict}, 32'd0);

        // Alias/replace at index 0
        upd(32'h100, 1'b1, 32'h80);
        upd(32'h140, 1'b1, 32'h200);
        chk("alias_mis", {31'd0, upd_mispredict}, 32'd1);
        look(32'h100);
        chk("alias_old_hit",    {31'd0, pred_hit}, 32'd0);
        chk("alias_old_target", pred_target,       32'h104);
        look(32'h140);
        chk("alias_new_hit",    {31'd0, pred_hit}, 32'd1);
        chk("alias_new_target", pred_target,       32'h200);

        // Not-taken miss does not allocate or evict
        upd(32'h300, 1'b0, 32'h0);
        chk("ntm_mis", {31'd0, upd_mispredict}, 32'd0);
        look(32'h300);
        chk("ntm_hit",    {31'd0, pred_hit}, 32'd0);
        chk("ntm_target", pred_target,       32'h304);
        look(32'h142);
        chk("lsb_ignored_hit", {31'd0, pred_hit}, 32'd1);

        // Taken hit with a new target counts as mispredict and retargets
        upd(32'h140, 1'b1, 32'h240);
        chk("tgt_mis", {31'd0, upd_mispredict}, 32'd1);
        look(32'h140);
        chk("tgt_new", pred_target, 32'h240);

        // fetch_pc+4 wraps
        look(32'hFFFF_FFFC);
        chk("wrap_target", pred_target, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
